// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg: shared state encoding and default parameters for btn_conditioner
package btn_cond_pkg;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_LONG_CYCLES = 16;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RISE_WAIT = 2'b01,
    HELD      = 2'b11,
    FALL_WAIT = 2'b10
  } btn_state_t;
endpackage

// File: rtl/btn_sync.sv
// btn_sync: two-flop synchroniser, async active-low reset to 0
// Ports: clk, rst_n, d (asynchronous input) -> q (synchronised, two cycles later)
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s2_q, s1_q} <= 2'b00;
    else {s2_q, s1_q} <= {s1_q, d};
  assign q = s2_q;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and edge-detect a raw push button
// Ports: clk, rst_n (async active-low), btn (raw) -> btn_level, press, release_p, long_press
// Optional: define BTN_LONG_PRESS_EN to enable the long-press detector
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_level,
  output logic press,
  output logic release_p,
  output logic long_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s2;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d;
  btn_sync u_sync (.clk(clk), .rst_n(rst_n), .d(btn), .q(s2));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    press_d = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s2) state_d = RISE_WAIT;
      end
      RISE_WAIT:
        if (!s2) begin
          state_d = IDLE;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d = '0;
          press_d = 1'b1;
        end
      HELD: begin
        cnt_d = '0;
        if (!s2) state_d = FALL_WAIT;
      end
      FALL_WAIT:
        if (s2) begin
          state_d = HELD;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d = '0;
          release_d = 1'b1;
        end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
    // HELD and FALL_WAIT share bit 1: the debounced level is high in both
    level_d = state_d[1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      release_q <= release_d;
    end
  assign btn_level = level_q;
  assign press = press_q;
  assign release_p = release_q;
`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  logic [HW-1:0] hold_q, hold_d;
  logic long_q, long_d;
  // Saturating at LONG_CYCLES makes the pulse one-shot until the next press clears it
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) hold_d = '0;
    else if (state_q == HELD || state_q == FALL_WAIT) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
      long_d = (hold_q == HOLD_MAX - 1'b1) && !release_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  assign long_press = long_q;
`else
  // long_press is constant 0; the term only keeps LONG_CYCLES referenced
  assign long_press = 1'b0 & (LONG_CYCLES > DEBOUNCE_CYCLES);
`endif
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: randomized scoreboard bench for btn_conditioner
module tb_btn_conditioner;
  localparam int D = 4;
  localparam int L = 16;
`ifdef BTN_LONG_PRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif
  typedef struct {
    int cyc;
    int kind;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic btn_level, press, release_p, long_press;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit lvl = 1'b0;
  int run = 0;
  int hc = 0;
  bit bq[$] = '{1'b0, 1'b0};
  ev_t q[$];
  string kname[3] = '{"press", "release", "long_press"};
  btn_conditioner dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .btn_level(btn_level),
    .press(press), .release_p(release_p), .long_press(long_press)
  );
  always #5 clk = ~clk;
  // Reference: btn reaches the debouncer two edges late; the level flips once
  // D+1 consecutive samples disagree with it; long fires L edges after a press.
  always @(posedge clk) begin
    bit s;
    if (!rst_n) begin
      bq = '{1'b0, 1'b0};
      lvl = 1'b0;
      run = 0;
      hc = 0;
    end else begin
      cyc++;
      s = bq.pop_front();
      bq.push_back(btn);
      run = (s != lvl) ? run + 1 : 0;
      if (run == D + 1) begin
        lvl = !lvl;
        run = 0;
        q.push_back('{cyc, lvl ? 0 : 1});
        if (lvl) hc = 0;
      end else if (lvl) begin
        hc++;
        if (LP && hc == L) q.push_back('{cyc, 2});
      end
    end
  end
  always @(negedge clk) begin
    int n, k;
    ev_t e;
    if (rst_n) begin
      n = int'(press) + int'(release_p) + int'(long_press);
      tests++;
      if (btn_level !== lvl) begin
        fails++;
        $display("FAIL btn_level cyc=%0d got=%0b exp=%0b", cyc, btn_level, lvl);
      end
      tests++;
      if (n > 1) begin
        fails++;
        $display("FAIL overlap cyc=%0d got=%0d pulses exp<=1", cyc, n);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missed %s got=none exp_cyc=%0d", kname[q[0].kind], q[0].cyc);
        void'(q.pop_front());
      end
      if (n == 1) begin
        k = press ? 0 : release_p ? 1 : 2;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected %s cyc=%0d got=1 exp=0", kname[k], cyc);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.kind != k) begin
            fails++;
            $display("FAIL pulse got=%s@%0d exp=%s@%0d", kname[k], cyc, kname[e.kind], e.cyc);
          end
        end
      end
    end
  end
  task automatic drive(input bit b, input int n);
    btn = b;
    repeat (n) @(negedge clk);
  endtask
  task automatic check_zero(input string tag);
    tests++;
    if ({btn_level, press, release_p, long_press} !== 4'b0000) begin
      fails++;
      $display("FAIL %s got=%b exp=0000", tag, {btn_level, press, release_p, long_press});
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    drive(0, 5);
    drive(1, 20);
    drive(0, 20);
    drive(1, 3);
    drive(0, 20);
    drive(1, 20);
    drive(0, 2);
    drive(1, 1);
    drive(0, 20);
    drive(1, 40);
    drive(0, 20);
    drive(1, 5);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_in_rise_wait");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 12);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_in_held");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 12);
    drive(0, 20);
    for (int i = 0; i < 100; i++) drive(1'($urandom_range(0, 1)), 2);
    for (int i = 0; i < 60; i++) drive(1'($urandom_range(0, 1)), $urandom_range(1, 10));
    drive(1, 25);
    drive(0, 30);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL leftover got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
